// File: rtl/mouse_transmitter_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing constants
// (also used by the receiver) and the odd-parity helper.
package mouse_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5,
        WAIT_IDLE = 3'd6,
        DONE      = 3'd7
    } tx_state_t;

    // 100us of clock inhibit at 100MHz before the request-to-send.
    localparam int unsigned DEFAULT_INHIBIT_CYCLES = 10000;
    // 20ms for the device to start clocking after the request.
    localparam int unsigned DEFAULT_START_TIMEOUT  = 2000000;
    // 1ms between consecutive device clock falls.
    localparam int unsigned DEFAULT_BIT_TIMEOUT    = 100000;

    localparam int TIMER_WIDTH = 21;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// Host-side handshake between the mouse master FSM and the transmitter.
interface mouse_transmitter_if;

    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BUSY;
    logic       BYTE_SENT;
    logic [1:0] BYTE_ERROR_CODE;

    modport master (
        output SEND_BYTE,
        output BYTE_TO_SEND,
        input  BUSY,
        input  BYTE_SENT,
        input  BYTE_ERROR_CODE
    );

    modport slave (
        input  SEND_BYTE,
        input  BYTE_TO_SEND,
        output BUSY,
        output BYTE_SENT,
        output BYTE_ERROR_CODE
    );

endinterface

// File: rtl/mouse_transmitter_clk_edge.sv
// Falling-edge detector for the (already synchronised) PS/2 clock pad.
module mouse_transmitter_clk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    output logic fall
);

    logic clk_dly;

    // Delay the pad by one system clock so a high-to-low step can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_dly <= 1'b0;
        end else begin
            clk_dly <= clk_in;
        end
    end

    assign fall = clk_dly & ~clk_in;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request to
// send, shifts out start/data/parity/stop on device clock falls and checks
// the device ACK. Pads are open-drain; the *_OUT_EN outputs pull them low.
module mouse_transmitter
    import mouse_transmitter_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT  = DEFAULT_START_TIMEOUT,
    parameter int unsigned BIT_TIMEOUT    = DEFAULT_BIT_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLK_MOUSE_IN,
    output logic                    CLK_MOUSE_OUT_EN,
    input  logic                    DATA_MOUSE_IN,
    output logic                    DATA_MOUSE_OUT,
    output logic                    DATA_MOUSE_OUT_EN,
    mouse_transmitter_if.slave      host
);

    localparam logic [TIMER_WIDTH-1:0] INHIBIT_LAST = TIMER_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] START_LAST   = TIMER_WIDTH'(START_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] BIT_LAST     = TIMER_WIDTH'(BIT_TIMEOUT - 1);

    tx_state_t              state, state_next;
    logic [TIMER_WIDTH-1:0] timer, timer_next;
    logic [7:0]             shifter, shifter_next;
    logic                   parity, parity_next;
    logic                   tx_bit, tx_bit_next;
    logic [3:0]             bit_cnt, bit_cnt_next;
    logic [1:0]             err, err_next;

    logic fall;
    logic fall_ok;
    logic clk_en;
    logic data_en;

    mouse_transmitter_clk_edge u_clk_edge (
        .clk    (CLK),
        .rst_n  (RESET),
        .clk_in (CLK_MOUSE_IN),
        .fall   (fall)
    );

    // Our own clock pull-down would otherwise look like a device edge.
    assign fall_ok = fall & ~clk_en;

    // State register plus the frame datapath; reset releases the pads at once
    // because every pad enable is decoded from the state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            timer   <= '0;
            shifter <= '0;
            parity  <= 1'b0;
            tx_bit  <= 1'b0;
            bit_cnt <= '0;
            err     <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            shifter <= shifter_next;
            parity  <= parity_next;
            tx_bit  <= tx_bit_next;
            bit_cnt <= bit_cnt_next;
            err     <= err_next;
        end
    end

    // Next-state, datapath updates and pad controls; a detected timeout drops
    // the data enable in the same cycle it is seen.
    always_comb begin
        state_next   = state;
        timer_next   = (timer == '1) ? timer : timer + 1'b1;
        shifter_next = shifter;
        parity_next  = parity;
        tx_bit_next  = tx_bit;
        bit_cnt_next = bit_cnt;
        err_next     = err;
        clk_en       = 1'b0;
        data_en      = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (host.SEND_BYTE) begin
                    shifter_next = host.BYTE_TO_SEND;
                    parity_next  = odd_parity(host.BYTE_TO_SEND);
                    err_next     = 2'b00;
                    tx_bit_next  = 1'b0;
                    bit_cnt_next = '0;
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_en = 1'b1;
                if (timer >= INHIBIT_LAST) begin
                    data_en    = 1'b1;
                    timer_next = '0;
                    state_next = REQUEST;
                end
            end

            REQUEST: begin
                data_en = 1'b1;
                if (fall_ok) begin
                    tx_bit_next  = shifter[0];
                    shifter_next = {1'b0, shifter[7:1]};
                    bit_cnt_next = 4'd1;
                    timer_next   = '0;
                    state_next   = DATA;
                end else if (timer >= START_LAST) begin
                    data_en     = 1'b0;
                    err_next[0] = 1'b1;
                    timer_next  = '0;
                    state_next  = DONE;
                end
            end

            DATA: begin
                data_en = 1'b1;
                if (fall_ok) begin
                    timer_next = '0;
                    if (bit_cnt == 4'd8) begin
                        tx_bit_next = parity;
                        state_next  = PARITY;
                    end else begin
                        tx_bit_next  = shifter[0];
                        shifter_next = {1'b0, shifter[7:1]};
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end else if (timer >= BIT_LAST) begin
                    data_en     = 1'b0;
                    err_next[0] = 1'b1;
                    timer_next  = '0;
                    state_next  = DONE;
                end
            end

            PARITY: begin
                data_en = 1'b1;
                if (fall_ok) begin
                    timer_next = '0;
                    state_next = STOP;
                end else if (timer >= BIT_LAST) begin
                    data_en     = 1'b0;
                    err_next[0] = 1'b1;
                    timer_next  = '0;
                    state_next  = DONE;
                end
            end

            STOP: begin
                if (fall_ok) begin
                    err_next[1] = DATA_MOUSE_IN;
                    timer_next  = '0;
                    state_next  = WAIT_IDLE;
                end else if (timer >= BIT_LAST) begin
                    err_next[0] = 1'b1;
                    timer_next  = '0;
                    state_next  = DONE;
                end
            end

            WAIT_IDLE: begin
                if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
                    timer_next = '0;
                    state_next = DONE;
                end else if (timer >= BIT_LAST) begin
                    err_next[0] = 1'b1;
                    timer_next  = '0;
                    state_next  = DONE;
                end
            end

            DONE: begin
                timer_next = '0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign CLK_MOUSE_OUT_EN     = clk_en;
    assign DATA_MOUSE_OUT_EN    = data_en;
    assign DATA_MOUSE_OUT       = data_en & tx_bit;
    assign host.BUSY            = (state != IDLE);
    assign host.BYTE_SENT       = (state == DONE);
    assign host.BYTE_ERROR_CODE = err;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: an open-drain mouse model clocks frames out of
// the DUT while a scoreboard checks each BYTE_SENT against queued results.
module tb_mouse_transmitter;

    localparam int INH      = 50;
    localparam int START_TO = 2000;
    localparam int BIT_TO   = 500;
    localparam int HALF     = 20;

    typedef struct {
        logic [9:0] frame;
        logic [9:0] mask;
        logic [1:0] err;
    } exp_t;

    logic CLK;
    logic RESET;
    logic clk_en;
    logic data_out;
    logic data_en;
    logic dev_clk_low;
    logic dev_data_low;
    logic clk_pad;
    logic data_pad;

    exp_t       exp_q[$];
    logic [9:0] dev_frame;
    int         dev_pulses;
    bit         abort;
    int         checks;
    int         failures;
    int         sent_count;
    int         pushes;

    mouse_transmitter_if host_if ();

    assign clk_pad  = ~(clk_en | dev_clk_low);
    assign data_pad = (data_en ? data_out : 1'b1) & ~dev_data_low;

    mouse_transmitter #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START_TO),
        .BIT_TIMEOUT    (BIT_TO)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .CLK_MOUSE_IN      (clk_pad),
        .CLK_MOUSE_OUT_EN  (clk_en),
        .DATA_MOUSE_IN     (data_pad),
        .DATA_MOUSE_OUT    (data_out),
        .DATA_MOUSE_OUT_EN (data_en),
        .host              (host_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pulse SEND_BYTE for one cycle; optionally queue the expected outcome.
    task automatic applyStimulus(input logic [7:0] value, input bit push,
                                 input logic [9:0] frame, input logic [9:0] mask,
                                 input logic [1:0] err);
        exp_t e;
        @(negedge CLK);
        host_if.SEND_BYTE    = 1'b1;
        host_if.BYTE_TO_SEND = value;
        if (push) begin
            e.frame = frame;
            e.mask  = mask;
            e.err   = err;
            exp_q.push_back(e);
            pushes++;
        end
        @(negedge CLK);
        host_if.SEND_BYTE = 1'b0;
        checkOutput("busy_after_accept", host_if.BUSY, 1);
        checkOutput("inhibit_clk_low", clk_en, 1);
    endtask

    // Stray SEND_BYTE pulse while a frame is in flight.
    task automatic pulseSend(input logic [7:0] value);
        @(negedge CLK);
        host_if.SEND_BYTE    = 1'b1;
        host_if.BYTE_TO_SEND = value;
        @(negedge CLK);
        host_if.SEND_BYTE = 1'b0;
    endtask

    // Mouse model: waits for the request-to-send, then produces 'pulses'
    // clock pulses, sampling data mid-high and pulling data low before the
    // eleventh fall when acknowledging.
    task automatic deviceFrame(input int pulses, input bit ack);
        int k;
        k = 0;
        dev_pulses = 0;
        while (!(clk_pad && !data_pad) && k < INH + 200 && !abort) begin
            @(negedge CLK);
            k++;
        end
        if (!(clk_pad && !data_pad) && !abort) begin
            checks++;
            failures++;
            $display("[TB] FAIL request_wait actual=no_request required=request");
            return;
        end
        repeat (10) @(negedge CLK);
        dev_frame = '0;
        for (int i = 0; i < pulses && !abort; i++) begin
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge CLK);
            end
            dev_clk_low = 1'b1;
            for (int c = 0; c < HALF && !abort; c++) @(negedge CLK);
            dev_clk_low = 1'b0;
            for (int c = 0; c < HALF / 2 && !abort; c++) @(negedge CLK);
            if (i < 10) dev_frame[i] = data_pad;
            for (int c = 0; c < HALF / 2 && !abort; c++) @(negedge CLK);
            dev_pulses++;
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    // Wait for the queued transaction to complete within a cycle budget.
    task automatic waitDone();
        int k;
        k = 0;
        while ((host_if.BUSY || exp_q.size() != 0) && k < 30000) begin
            @(negedge CLK);
            k++;
        end
        checkOutput("done_in_time", host_if.BUSY, 0);
        repeat (5) @(negedge CLK);
    endtask

    // Scoreboard monitor: every completion pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET && host_if.BYTE_SENT) begin
                sent_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_byte_sent actual=pulse required=none");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("error_code", host_if.BYTE_ERROR_CODE, e.err);
                    checkOutput("clk_released", clk_en, 0);
                    checkOutput("data_released", data_en, 0);
                    if (e.mask != 0) checkOutput("frame_bits", dev_frame & e.mask, e.frame & e.mask);
                    @(negedge CLK);
                    checkOutput("busy_cleared", host_if.BUSY, 0);
                    checkOutput("sent_one_cycle", host_if.BYTE_SENT, 0);
                end
            end
        end
    end

    initial begin
        int base;
        checks = 0; failures = 0; sent_count = 0; pushes = 0;
        abort = 1'b0; dev_clk_low = 1'b0; dev_data_low = 1'b0; dev_frame = '0; dev_pulses = 0;
        host_if.SEND_BYTE = 1'b0;
        host_if.BYTE_TO_SEND = 8'h00;
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        checkOutput("reset_busy", host_if.BUSY, 0);
        checkOutput("reset_sent", host_if.BYTE_SENT, 0);
        checkOutput("reset_err", host_if.BYTE_ERROR_CODE, 0);
        checkOutput("reset_clk_en", clk_en, 0);
        checkOutput("reset_data_en", data_en, 0);
        checkOutput("reset_data_out", data_out, 0);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        $display("[TB] 0xF4 with ACK");
        fork
            applyStimulus(8'hF4, 1, 10'h2F4, 10'h3FF, 2'b00);
            deviceFrame(11, 1);
        join
        waitDone();

        $display("[TB] 0xFF without ACK");
        fork
            applyStimulus(8'hFF, 1, 10'h3FF, 10'h3FF, 2'b10);
            deviceFrame(11, 0);
        join
        waitDone();

        $display("[TB] 0x00, device silent");
        applyStimulus(8'h00, 1, 10'h000, 10'h000, 2'b01);
        waitDone();

        $display("[TB] 0xA5, device stops after bit3");
        fork
            applyStimulus(8'hA5, 1, 10'h0A5, 10'h00F, 2'b01);
            deviceFrame(4, 1);
        join
        waitDone();

        $display("[TB] 0x5A with stray SEND_BYTE pulses");
        base = sent_count;
        fork
            applyStimulus(8'h5A, 1, 10'h35A, 10'h3FF, 2'b00);
            deviceFrame(11, 1);
            begin
                repeat (30) @(negedge CLK);
                pulseSend(8'h00);
                repeat (300) @(negedge CLK);
                pulseSend(8'hFF);
            end
        join
        waitDone();
        checkOutput("single_completion", sent_count - base, 1);

        $display("[TB] reset during DATA");
        fork
            applyStimulus(8'h3C, 0, 10'h000, 10'h000, 2'b00);
            deviceFrame(11, 1);
            begin
                int k;
                k = 0;
                while (dev_pulses < 3 && k < 2000) begin
                    @(negedge CLK);
                    k++;
                end
                checkOutput("pre_reset_data_en", data_en, 1);
                #2 RESET = 1'b0;
                #1;
                checkOutput("async_clk_en", clk_en, 0);
                checkOutput("async_data_en", data_en, 0);
                checkOutput("async_busy", host_if.BUSY, 0);
                checkOutput("async_data_out", data_out, 0);
                abort = 1'b1;
            end
        join
        repeat (5) @(negedge CLK);
        abort = 1'b0;
        RESET = 1'b1;
        repeat (5) @(negedge CLK);

        $display("[TB] 0xF4 after reset");
        fork
            applyStimulus(8'hF4, 1, 10'h2F4, 10'h3FF, 2'b00);
            deviceFrame(11, 1);
        join
        waitDone();

        checkOutput("total_completions", sent_count, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
